sme_scan_ctrl: RTL



---
 rtl/sme_scan_ctrl.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/sme_scan_ctrl.sv
// String-match scan controller: buffers a string and a pattern, then searches one compare per cycle.
// Optional feature: define SME_DOT_EN to make '.' in the pattern a single-char wildcard.
module sme_scan_ctrl #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       isstring_i,
  input  logic                       ispattern_i,
  input  logic [7:0]                 chardata_i,
  output logic                       busy_o,
  output logic                       match_v_o,
  output logic                       m_done_o,
  output logic [$clog2(STR_MAX)-1:0] m_idx_o
);
  localparam int SW  = $clog2(STR_MAX+1);
  localparam int PW  = $clog2(PAT_MAX+1);
  localparam int IW  = $clog2(STR_MAX);
  localparam int PIW = $clog2(PAT_MAX);

  typedef enum logic [2:0] {IDLE, LOAD_STR, LOAD_PAT, SCAN, REPORT} state_e;

  state_e                    state_q, state_d;
  logic [STR_MAX-1:0][7:0]   str_q, str_d;
  logic [PAT_MAX-1:0][7:0]   pat_q, pat_d;
  logic [SW-1:0]             slen_q, slen_d, s_q, s_d, p_q, p_d;
  logic [PW-1:0]             plen_q, plen_d, q_q, q_d;
  logic                      busy_q, busy_d, mv_q, mv_d, md_q, md_d;
  logic [IW-1:0]             idx_q, idx_d;

  logic [7:0] pc, sc, sprev;
  logic       in_str, step_ok, adv_p, dot_hit;

  assign pc     = pat_q[q_q[PIW-1:0]];
  assign sc     = str_q[p_q[IW-1:0]];
  assign sprev  = str_q[s_q[IW-1:0] - IW'(1)];
  assign in_str = (p_q < slen_q);
`ifdef SME_DOT_EN
  assign dot_hit = (pc == 8'h2E);
`else
  assign dot_hit = 1'b0;
`endif

  // Anchors are only special at their legal positions; elsewhere they compare literally.
  always_comb begin
    step_ok = 1'b0;
    adv_p   = 1'b0;
    if (pc == 8'h5E && q_q == '0)
      step_ok = (s_q == '0) || (sprev == 8'h20);
    else if (pc == 8'h24 && q_q == plen_q - PW'(1))
      step_ok = !in_str || (sc == 8'h20);
    else begin
      step_ok = in_str && ((sc == pc) || dot_hit);
      adv_p   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    str_d   = str_q;
    pat_d   = pat_q;
    slen_d  = slen_q;
    plen_d  = plen_q;
    s_d     = s_q;
    p_d     = p_q;
    q_d     = q_q;
    mv_d    = 1'b0;
    md_d    = 1'b0;
    idx_d   = '0;
    case (state_q)
      IDLE, LOAD_STR: begin
        if (ispattern_i) begin
          state_d  = LOAD_PAT;
          pat_d[0] = chardata_i;
          plen_d   = PW'(1);
        end else if (isstring_i) begin
          state_d = LOAD_STR;
          if (state_q == IDLE) begin
            str_d[0] = chardata_i;
            slen_d   = SW'(1);
          end else if (slen_q < SW'(STR_MAX)) begin
            str_d[slen_q[IW-1:0]] = chardata_i;
            slen_d                = slen_q + SW'(1);
          end
        end
      end
      LOAD_PAT: begin
        if (ispattern_i) begin
          if (plen_q < PW'(PAT_MAX)) begin
            pat_d[plen_q[PIW-1:0]] = chardata_i;
            plen_d                 = plen_q + PW'(1);
          end
        end else begin
          state_d = SCAN;
          s_d     = '0;
          p_d     = '0;
          q_d     = '0;
        end
      end
      SCAN: begin
        if (step_ok) begin
          q_d = q_q + PW'(1);
          if (adv_p) p_d = p_q + SW'(1);
          if (q_q + PW'(1) == plen_q) begin
            state_d = REPORT;
            mv_d    = 1'b1;
            idx_d   = s_q[IW-1:0];
          end
        end else begin
          s_d = s_q + SW'(1);
          p_d = s_q + SW'(1);
          q_d = '0;
          // >= also terminates an empty-string search after one step
          if (s_q + SW'(1) >= slen_q) begin
            state_d = REPORT;
            md_d    = 1'b1;
          end
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SCAN) || (state_d == REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      str_q   <= '0;
      pat_q   <= '0;
      slen_q  <= '0;
      plen_q  <= '0;
      s_q     <= '0;
      p_q     <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      mv_q    <= 1'b0;
      md_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      str_q   <= str_d;
      pat_q   <= pat_d;
      slen_q  <= slen_d;
      plen_q  <= plen_d;
      s_q     <= s_d;
      p_q     <= p_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      mv_q    <= mv_d;
      md_q    <= md_d;
      idx_q   <= idx_d;
    end
  end

  assign busy_o    = busy_q;
  assign match_v_o = mv_q;
  assign m_done_o  = md_q;
  assign m_idx_o   = idx_q;
endmodule
